// File: rtl/csr_row_encoder.sv
// Dense-to-CSR row encoder: captures one dense row, scans one element per cycle,
// and presents the packed column indices, non-zero values and count until taken.
module csr_row_encoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned H_NUM_OF_COLS  = 5,
  parameter int unsigned COL_IDX_WIDTH  = $clog2(H_NUM_OF_COLS),
  parameter int unsigned ROW_LEN_WIDTH  = $clog2(H_NUM_OF_COLS),
  parameter int unsigned ROW_INFO_WIDTH = ROW_LEN_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      row_valid_i,
  output logic                      row_ready_o,
  input  logic [DATA_WIDTH-1:0]     row_dense_i   [H_NUM_OF_COLS],
  output logic                      csr_valid_o,
  input  logic                      csr_ready_i,
  output logic [COL_IDX_WIDTH-1:0]  row_col_idx_o [H_NUM_OF_COLS],
  output logic [DATA_WIDTH-1:0]     row_value_o   [H_NUM_OF_COLS],
  output logic [ROW_INFO_WIDTH-1:0] row_info_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]                state;
  logic [DATA_WIDTH-1:0]     buffer  [H_NUM_OF_COLS];
  logic [COL_IDX_WIDTH-1:0]  k;
  logic [ROW_INFO_WIDTH-1:0] nnz;
  logic [COL_IDX_WIDTH-1:0]  col_idx [H_NUM_OF_COLS];
  logic [DATA_WIDTH-1:0]     value   [H_NUM_OF_COLS];
  logic [DATA_WIDTH-1:0]     cur;
  logic                      last;

  always_comb begin
    cur = '0;
    for (int i = 0; i < int'(H_NUM_OF_COLS); i++) begin
      if (int'(k) == i) cur = buffer[i];
    end
  end

  assign last = (k == COL_IDX_WIDTH'(H_NUM_OF_COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      nnz   <= '0;
      for (int i = 0; i < int'(H_NUM_OF_COLS); i++) begin
        buffer[i]  <= '0;
        col_idx[i] <= '0;
        value[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (row_valid_i) begin
            k     <= '0;
            nnz   <= '0;
            state <= SCAN;
            for (int i = 0; i < int'(H_NUM_OF_COLS); i++) begin
              buffer[i]  <= row_dense_i[i];
              col_idx[i] <= '0;
              value[i]   <= '0;
            end
          end
        end
        SCAN: begin
          // Any set bit counts as non-zero; slots past nnz stay cleared from accept.
          if (cur != '0) begin
            for (int i = 0; i < int'(H_NUM_OF_COLS); i++) begin
              if (i == int'(nnz)) begin
                col_idx[i] <= k;
                value[i]   <= cur;
              end
            end
            nnz <= nnz + ROW_INFO_WIDTH'(1);
          end
          k <= k + COL_IDX_WIDTH'(1);
          if (last) state <= OUT;
        end
        OUT: begin
          if (csr_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign row_ready_o   = (state == IDLE) && !rst;
  assign csr_valid_o   = (state == OUT);
  assign row_col_idx_o = col_idx;
  assign row_value_o   = value;
  assign row_info_o    = nnz;

endmodule

// File: tb/tb_csr_row_encoder.sv
// Randomized and directed bench for csr_row_encoder against a packing reference model.
module tb_csr_row_encoder;
  localparam int DW = 8;
  localparam int H  = 5;
  localparam int CW = $clog2(H);
  localparam int IW = CW + 1;

  typedef logic [DW-1:0] row_t [H];

  logic          clk = 1'b0;
  logic          rst;
  logic          row_valid_i;
  logic          row_ready_o;
  row_t          row_dense_i;
  logic          csr_valid_o;
  logic          csr_ready_i;
  logic [CW-1:0] row_col_idx_o [H];
  row_t          row_value_o;
  logic [IW-1:0] row_info_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  csr_row_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .row_valid_i   (row_valid_i),
    .row_ready_o   (row_ready_o),
    .row_dense_i   (row_dense_i),
    .csr_valid_o   (csr_valid_o),
    .csr_ready_i   (csr_ready_i),
    .row_col_idx_o (row_col_idx_o),
    .row_value_o   (row_value_o),
    .row_info_o    (row_info_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the dense row and append every non-zero column in order.
  task automatic check_out(input string tag, input row_t r);
    int ei [H];
    int ev [H];
    int j;
    j = 0;
    for (int c = 0; c < H; c++) begin
      ei[c] = 0;
      ev[c] = 0;
    end
    for (int c = 0; c < H; c++) begin
      if (r[c] != 0) begin
        ei[j] = c;
        ev[j] = int'(r[c]);
        j++;
      end
    end
    check($sformatf("%s info", tag), 32'(row_info_o), j);
    for (int c = 0; c < H; c++) begin
      check($sformatf("%s idx[%0d]", tag, c), 32'(row_col_idx_o[c]), ei[c]);
      check($sformatf("%s val[%0d]", tag, c), 32'(row_value_o[c]), ev[c]);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s valid", tag), 32'(csr_valid_o), 0);
    check($sformatf("%s info", tag), 32'(row_info_o), 0);
    for (int c = 0; c < H; c++) begin
      check($sformatf("%s idx[%0d]", tag, c), 32'(row_col_idx_o[c]), 0);
      check($sformatf("%s val[%0d]", tag, c), 32'(row_value_o[c]), 0);
    end
  endtask

  task automatic send_row(input row_t r, input string tag);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    row_valid_i = 1'b1;
    row_dense_i = r;
    for (int i = 0; i < 30; i++) begin
      if (row_ready_o) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 row_valid_i = 1'b0;
    check($sformatf("%s accepted", tag), 32'(ok), 1);
  endtask

  task automatic run_row(input row_t r, input int stall, input bit alter, input string tag,
                         output int t_valid);
    int   n;
    row_t junk;
    for (int c = 0; c < H; c++) junk[c] = 8'($urandom_range(1, 255));
    send_row(r, tag);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (alter && i == 0) row_dense_i = junk;
      if (csr_valid_o) break;
    end
    t_valid = cyc;
    check($sformatf("%s latency", tag), n, 6);
    check($sformatf("%s valid", tag), 32'(csr_valid_o), 1);
    check_out(tag, r);
    if (stall > 0) begin
      csr_ready_i = 1'b0;
      row_valid_i = 1'b1;
      row_dense_i = junk;
      repeat (stall) begin
        @(negedge clk);
        check($sformatf("%s stall ready", tag), 32'(row_ready_o), 0);
        check($sformatf("%s stall valid", tag), 32'(csr_valid_o), 1);
        check_out($sformatf("%s stall", tag), r);
      end
    end
    csr_ready_i = 1'b1;
    @(posedge clk);
    #1 row_valid_i = 1'b0;
    check($sformatf("%s post valid", tag), 32'(csr_valid_o), 0);
    check($sformatf("%s post ready", tag), 32'(row_ready_o), 1);
  endtask

  initial begin
    row_t r;
    int   t0, t1, t2;
    rst         = 1'b1;
    row_valid_i = 1'b0;
    csr_ready_i = 1'b0;
    for (int c = 0; c < H; c++) row_dense_i[c] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(row_ready_o), 0);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle ready", 32'(row_ready_o), 1);

    r = '{8'd0, 8'd3, 8'd0, 8'd0, 8'd7};
    run_row(r, 0, 1'b0, "sparse", t0);
    r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_row(r, 0, 1'b0, "zero", t0);
    r = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    run_row(r, 0, 1'b0, "full", t0);
    r = '{8'd0, 8'd9, 8'd0, 8'd4, 8'd0};
    run_row(r, 10, 1'b0, "backpressure", t0);
    r = '{8'd6, 8'd0, 8'd0, 8'd2, 8'd0};
    run_row(r, 0, 1'b1, "alter", t0);

    r = '{8'h80, 8'd0, 8'd0, 8'd0, 8'd1};
    run_row(r, 0, 1'b0, "b2b0", t0);
    r = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_row(r, 0, 1'b0, "b2b1", t1);
    r = '{8'd9, 8'd0, 8'd9, 8'd0, 8'd9};
    run_row(r, 0, 1'b0, "b2b2", t2);
    check("b2b spacing 01", t1 - t0, 7);
    check("b2b spacing 12", t2 - t1, 7);

    // Reset two edges into the scan must drop the row without any output.
    r = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    send_row(r, "midscan");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midscan rst ready", 32'(row_ready_o), 0);
    check_zero("midscan rst");
    @(negedge clk);
    rst = 1'b0;
    #1 check("midscan release ready", 32'(row_ready_o), 1);
    r = '{8'd0, 8'd0, 8'd5, 8'd0, 8'd0};
    run_row(r, 0, 1'b0, "after reset", t0);

    for (int n = 0; n < 20; n++) begin
      for (int c = 0; c < H; c++) begin
        r[c] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'd0;
      end
      run_row(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", n), t0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
